signed_divider: RTL and testbench

SIGNED_DIVIDER -- requirements
Module: signed_divider

---
 rtl/signed_divider_pkg.sv | 32 +++
 rtl/signed_divider_div_step.sv | 22 ++
 rtl/signed_divider.sv | 136 +++++++++++++
 tb/tb_signed_divider.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/signed_divider_pkg.sv
// Shared types and constants for the signed divider.
// Holds the FSM encoding, operand widths and the magnitude helpers.
package signed_divider_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER_COUNT = 8;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Two's-complement magnitude; the most negative value maps onto
    // its own bit pattern, which reads correctly as unsigned.
    function automatic logic [DIVIDEND_W-1:0] mag_dvd(
        input logic [DIVIDEND_W-1:0] x
    );
        return x[DIVIDEND_W-1] ? -x : x;
    endfunction

    function automatic logic [DIVISOR_W-1:0] mag_dvs(
        input logic [DIVISOR_W-1:0] x
    );
        return x[DIVISOR_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/signed_divider_div_step.sv
// One restoring trial-subtract step of the divider.
// Ports: rem_in (9b shifted partial remainder), dvs (8b), rem_out, q_bit.
module div_step
    import signed_divider_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic [DIVISOR_W-1:0] dvs,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    // After a successful subtract the result is below dvs, so the
    // 8-bit modular difference is exact.
    always_comb begin
        q_bit   = (rem_in >= {1'b0, dvs});
        rem_out = rem_in[DIVISOR_W-1:0];
        if (q_bit) begin
            rem_out = rem_in[DIVISOR_W-1:0] - dvs;
        end
    end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed 16/8 divider, truncating toward zero, fixed latency.
// Ports: clk, reset(n), start, dividend, divisor -> quotient, remainder,
//        busy, done, div_by_zero, overflow.
module signed_divider
    import signed_divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_COUNT - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DIVIDEND_W-1:0]   dvd_q;
    logic [DIVISOR_W-1:0]    dvs_q;
    logic [DIVISOR_W-1:0]    dvs_mag;
    logic [DIVISOR_W:0]      prem;
    logic [DIVISOR_W-1:0]    dlo;
    logic                    qneg;
    logic                    rneg;

    logic [DIVIDEND_W-1:0]   dvd_abs;
    logic [DIVISOR_W-1:0]    dvs_abs;
    logic [DIVISOR_W-1:0]    step_rem;
    logic                    step_q;
    logic [DIVISOR_W-1:0]    r_mag;
    logic                    q_big;
    logic                    ovf_fix;
    logic                    err_fix;

    assign dvd_abs = mag_dvd(dvd_q);
    assign dvs_abs = mag_dvs(dvs_q);

    div_step u_step (
        .rem_in  (prem),
        .dvs     (dvs_mag),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // prem always holds the already-shifted trial value, so the final
    // remainder sits in its upper 8 bits once the last step is done.
    // dlo shifts dividend bits out at the top and quotient bits in at
    // the bottom, ending up as the quotient magnitude.
    assign r_mag = prem[DIVISOR_W:1];

    // A negative result may reach -128; a positive one stops at 127.
    // A zero divisor yields an all-ones magnitude, which is not an
    // overflow in its own right.
    always_comb begin
        q_big   = qneg ? (dlo > 8'd128) : (dlo > 8'd127);
        ovf_fix = overflow | (~div_by_zero & q_big);
        err_fix = ovf_fix | div_by_zero;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvs_mag     <= '0;
            prem        <= '0;
            dlo         <= '0;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        dvd_q       <= dividend;
                        dvs_q       <= divisor;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dvs_mag     <= dvs_abs;
                    prem        <= {dvd_abs[15:8], dvd_abs[7]};
                    dlo         <= {dvd_abs[6:0], 1'b0};
                    qneg        <= dvd_q[15] ^ dvs_q[7];
                    rneg        <= dvd_q[15];
                    div_by_zero <= (dvs_q == '0);
                    overflow    <= (dvs_q != '0) &&
                                   (dvd_abs[15:8] >= dvs_abs);
                    cnt         <= '0;
                    state       <= S_ITER;
                end
                S_ITER: begin
                    prem <= {step_rem, dlo[7]};
                    dlo  <= {dlo[6:0], step_q};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    overflow <= ovf_fix;
                    if (err_fix) begin
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        quotient  <= qneg ? -dlo : dlo;
                        remainder <= rneg ? -r_mag : r_mag;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider.
// Directed corner cases plus randomized operands against an integer model.
module tb_signed_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int nvec;
    int nerr;

    signed_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division (truncating) and modulo.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov);
        int ia;
        int ib;
        int iq;
        int ir;
        ia = int'($signed(a));
        ib = int'($signed(b));
        dz = (ib == 0);
        ov = 1'b0;
        q  = 8'h00;
        r  = 8'h00;
        if (!dz) begin
            iq = ia / ib;
            ir = ia % ib;
            ov = (iq > 127) || (iq < -128);
            if (!ov) begin
                q = 8'(iq);
                r = 8'(ir);
            end
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                         input bit inject, input string tag);
        int n;
        bit busy_ok;
        logic [7:0] eq;
        logic [7:0] er;
        logic edz;
        logic eov;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (inject && n == 4) begin
                start    = 1'b1;
                dividend = ~a;
                divisor  = b + 8'd3;
            end else if (inject && n == 5) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        model(a, b, eq, er, edz, eov);
        chk({tag, ":latency"}, n, 10);
        chk({tag, ":busy_run"}, {31'd0, busy_ok}, 1);
        chk({tag, ":quotient"}, {24'd0, quotient}, {24'd0, eq});
        chk({tag, ":remainder"}, {24'd0, remainder}, {24'd0, er});
        chk({tag, ":div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
        chk({tag, ":overflow"}, {31'd0, overflow}, {31'd0, eov});
        chk({tag, ":busy_end"}, {31'd0, busy}, 0);
        @(posedge clk);
        #1;
        chk({tag, ":hold"}, {22'd0, done, div_by_zero, quotient, remainder},
            {22'd0, 1'b1, edz, eq, er});
    endtask

    initial begin
        logic signed [15:0] ra;
        logic [7:0] rb;
        nvec     = 0;
        nerr     = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("reset_outs", {18'd0, quotient, remainder, busy, done,
            div_by_zero, overflow}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        do_op(16'd100, 8'd7, 1'b0, "100/7");
        do_op(16'(-100), 8'd7, 1'b0, "-100/7");
        do_op(16'd1000, 8'(-8), 1'b0, "1000/-8");
        do_op(16'(-1024), 8'd8, 1'b0, "-1024/8");
        do_op(16'd32767, 8'd127, 1'b0, "32767/127");
        do_op(16'h8000, 8'h80, 1'b0, "-32768/-128");
        do_op(16'h1234, 8'd0, 1'b0, "1234h/0");
        do_op(16'd127, 8'd1, 1'b0, "127/1");
        do_op(16'd128, 8'd1, 1'b0, "128/1");
        do_op(16'(-128), 8'd1, 1'b0, "-128/1");
        do_op(16'd100, 8'd7, 1'b1, "inject");

        @(negedge clk);
        dividend = 16'h7000;
        divisor  = 8'h77;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_busy", {31'd0, busy}, 1);
        reset = 1'b0;
        #1;
        chk("midop_reset", {18'd0, quotient, remainder, busy, done,
            div_by_zero, overflow}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_op(16'd50, 8'd5, 1'b0, "50/5");

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            ra = ra >>> $urandom_range(0, 9);
            rb = 8'($urandom);
            if ($urandom_range(0, 15) == 0) rb = 8'd0;
            do_op(ra, rb, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
